least_recently_used_4_elmt: RTL and testbench

Least-recently-used (LRU) tracker for a 4-entry set, such as a 4-way cache set or a 4-slot resource pool. It keeps a full recency order of the four element indices and always presents the current LRU index as the replacement victim. Clients either touch a named element (access) or consume and refill the current victim (update). Single clock domain, no memory arrays.

---
 rtl/least_recently_used_4_elmt.sv | 59 +++++
 tb/tb_least_recently_used_4_elmt.sv | 132 +++++++++++++
 2 files changed

// File: rtl/least_recently_used_4_elmt.sv
// LRU tracker for a 4-entry set: keeps a full recency list, presents the LRU index as victim.
// Latency: a touch at edge N is visible on index_o after edge N; index_o decodes registered state only.
// Backpressure: none; access or update completes in the same cycle, access has priority over update.
module least_recently_used_4_elmt (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] index_i,
  input  logic       access,
  input  logic       update,
  output logic [1:0] index_o
);

  // rank_q[0] is the LRU element, rank_q[3] the MRU element; always a permutation of 0..3.
  logic [3:0][1:0] rank_q;
  logic [3:0][1:0] rank_d;

  logic       touch_en;
  logic [1:0] touch_idx;
  logic [1:0] touch_pos;

  // Pick the element to promote: an explicit access wins, otherwise update refills the victim.
  always_comb begin
    touch_en  = access | update;
    touch_idx = access ? index_i : rank_q[0];
  end

  // Locate the rank currently holding the touched element (exactly one rank matches).
  always_comb begin
    touch_pos = 2'd3;
    if (rank_q[0] == touch_idx) begin
      touch_pos = 2'd0;
    end else if (rank_q[1] == touch_idx) begin
      touch_pos = 2'd1;
    end else if (rank_q[2] == touch_idx) begin
      touch_pos = 2'd2;
    end
  end

  // Ranks below the touched one keep their place, ranks above slide down, touched element goes to MRU.
  always_comb begin
    rank_d    = rank_q;
    rank_d[0] = (touch_pos > 2'd0) ? rank_q[0] : rank_q[1];
    rank_d[1] = (touch_pos > 2'd1) ? rank_q[1] : rank_q[2];
    rank_d[2] = (touch_pos > 2'd2) ? rank_q[2] : rank_q[3];
    rank_d[3] = touch_idx;
  end

  // Recency list register; reset restores the identity order and discards all history.
  always_ff @(posedge clk) begin
    if (rst) begin
      rank_q <= {2'd3, 2'd2, 2'd1, 2'd0};
    end else if (touch_en) begin
      rank_q <= rank_d;
    end
  end

  assign index_o = rank_q[0];

endmodule

// File: tb/tb_least_recently_used_4_elmt.sv
// Bench for the 4-entry LRU tracker: directed test-plan steps followed by randomized traffic.
// Expected values come from explicit constants or a queue-based recency model.
// Inputs change on the falling edge; index_o is sampled on the falling edge after each rising edge.
module tb_least_recently_used_4_elmt;

  logic       clk;
  logic       rst;
  logic [1:0] index_i;
  logic       access;
  logic       update;
  logic [1:0] index_o;

  int vectors;
  int miscompares;

  // Recency model: element 0 of the queue is least recently used, last element is most recently used.
  int model[$];

  least_recently_used_4_elmt dut (
    .clk     (clk),
    .rst     (rst),
    .index_i (index_i),
    .access  (access),
    .update  (update),
    .index_o (index_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    model = {0, 1, 2, 3};
  endtask

  task automatic model_touch(input int x);
    for (int k = 0; k < model.size(); k++) begin
      if (model[k] == x) begin
        model.delete(k);
        break;
      end
    end
    model.push_back(x);
  endtask

  // Apply one cycle of stimulus, advance the model, then compare index_o.
  // exp < 0 means the model supplies the expected value.
  task automatic step(input logic r, input logic a, input logic u, input int idx,
                      input int exp, input string tag);
    int expected;
    rst     = r;
    access  = a;
    update  = u;
    index_i = idx[1:0];
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (a) begin
      model_touch(idx);
    end else if (u) begin
      model_touch(model[0]);
    end
    @(negedge clk);
    expected = (exp < 0) ? model[0] : exp;
    vectors++;
    assert (int'(index_o) === expected)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", tag, index_o, expected);
      end
  endtask

  initial begin
    int ra, ru, ri, rr;
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    access  = 1'b0;
    update  = 1'b0;
    index_i = 2'd0;
    model_reset();
    @(negedge clk);

    // 1. Reset and idle hold
    step(1'b1, 1'b0, 1'b0, 0, 0, "reset");
    step(1'b0, 1'b0, 1'b0, 0, 0, "idle0");
    step(1'b0, 1'b0, 1'b0, 0, 0, "idle1");
    step(1'b0, 1'b0, 1'b0, 0, 0, "idle2");

    // 2. Sequential touch 0..3
    step(1'b0, 1'b1, 1'b0, 0, 1, "seq_touch0");
    step(1'b0, 1'b1, 1'b0, 1, 2, "seq_touch1");
    step(1'b0, 1'b1, 1'b0, 2, 3, "seq_touch2");
    step(1'b0, 1'b1, 1'b0, 3, 0, "seq_touch3");

    // 3. Update refill from list 0,1,2,3
    step(1'b0, 1'b0, 1'b1, 0, 1, "update_refill");

    // 4. Round-robin update after reset
    step(1'b1, 1'b0, 1'b0, 0, 0, "rr_reset");
    step(1'b0, 1'b0, 1'b1, 2, 1, "rr_upd0");
    step(1'b0, 1'b0, 1'b1, 2, 2, "rr_upd1");
    step(1'b0, 1'b0, 1'b1, 2, 3, "rr_upd2");
    step(1'b0, 1'b0, 1'b1, 2, 0, "rr_upd3");
    step(1'b0, 1'b0, 1'b1, 2, 1, "rr_upd4");

    // 5. MRU re-touch and access-over-update priority
    step(1'b1, 1'b0, 1'b0, 0, 0, "prio_reset");
    step(1'b0, 1'b1, 1'b0, 3, 0, "mru_retouch");
    step(1'b0, 1'b1, 1'b1, 0, 1, "access_wins");
    step(1'b0, 1'b0, 1'b1, 0, 2, "after_prio_upd");

    // 6. Mid-operation reset overrides access
    step(1'b1, 1'b0, 1'b0, 0, 0, "mid_reset0");
    step(1'b0, 1'b1, 1'b0, 0, 1, "mid_touch0");
    step(1'b0, 1'b1, 1'b0, 2, 1, "mid_touch2");
    step(1'b1, 1'b1, 1'b0, 1, 0, "mid_rst_access");
    step(1'b0, 1'b0, 1'b1, 0, 1, "post_rst_upd");

    // Randomized traffic against the recency model
    for (int n = 0; n < 400; n++) begin
      ra = $urandom_range(0, 1);
      ru = $urandom_range(0, 1);
      ri = $urandom_range(0, 3);
      rr = ($urandom_range(0, 39) == 0) ? 1 : 0;
      step(rr[0], ra[0], ru[0], ri, -1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
